// File: rtl/zle_arb2.sv
// Two-input stream arbiter: grants one producer for a whole EOS-delimited
// segment, alternating round-robin between segments; o_s tags the source.
module zle_arb2 #(
    parameter int W        = 2,
    parameter int CW       = 8,
    parameter int MAXBURST = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] i0_d,
    input  logic         i0_e,
    input  logic         i0_v,
    output logic         i0_b,
    input  logic [W-1:0] i1_d,
    input  logic         i1_e,
    input  logic         i1_v,
    output logic         i1_b,
    output logic [W-1:0] o_d,
    output logic         o_e,
    output logic         o_v,
    input  logic         o_b,
    output logic         o_s
);

    typedef enum logic [1:0] {IDLE, G0, G1} st_t;

    localparam bit            LIMITED = (MAXBURST != 0);
    localparam logic [CW-1:0] CNT_END = CW'(MAXBURST - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    st_t           st, st_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    // Shared view of whichever input is granted; only meaningful in G0/G1.
    logic         k;
    logic         g_v, g_e, other_v, xfer, release_seg;
    logic [W-1:0] g_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st   <= IDLE;
            last <= 1'b1;
            cnt  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values computed by the comb block.
            st   <= st_nxt;
            last <= last_nxt;
            cnt  <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first, so no path through
        // the case statement can leave a signal unassigned and infer a latch.
        st_nxt      = st;
        last_nxt    = last;
        cnt_nxt     = cnt;
        o_d         = '0;
        o_e         = 1'b0;
        o_v         = 1'b0;
        o_s         = 1'b0;
        i0_b        = 1'b1;
        i1_b        = 1'b1;
        k           = (st == G1);
        g_v         = k ? i1_v : i0_v;
        g_e         = k ? i1_e : i0_e;
        g_d         = k ? i1_d : i0_d;
        other_v     = k ? i0_v : i1_v;
        xfer        = 1'b0;
        release_seg = 1'b0;

        case (st)
            IDLE: begin
                if (i0_v && i1_v) st_nxt = last ? G0 : G1;
                else if (i0_v)    st_nxt = G0;
                else if (i1_v)    st_nxt = G1;
            end
            G0, G1: begin
                o_d = g_d;
                o_e = g_e;
                o_v = g_v;
                o_s = k;
                if (k) i1_b = o_b;
                else   i0_b = o_b;

                xfer        = g_v && !o_b;
                release_seg = xfer && (g_e || (LIMITED && cnt == CNT_END));

                if (release_seg) begin
                    // Re-arbitrate with this input as last: the other side wins
                    // if it is waiting, so back-to-back switches cost no bubble.
                    last_nxt = k;
                    cnt_nxt  = '0;
                    if (other_v)  st_nxt = k ? G0 : G1;
                    else if (g_v) st_nxt = st;
                    else          st_nxt = IDLE;
                end else if (xfer && cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_zle_arb2.sv
// Directed bench for zle_arb2: one unlimited-burst instance and one with
// MAXBURST=4 sharing the same producer stimulus and downstream backpressure.
module tb_zle_arb2;

    localparam int W = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] i0_d, i1_d;
    logic         i0_e, i0_v, i1_e, i1_v, o_b;

    logic [W-1:0] o_d, mb_o_d;
    logic         o_e, o_v, o_s, i0_b, i1_b;
    logic         mb_o_e, mb_o_v, mb_o_s, mb_i0_b, mb_i1_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    zle_arb2 #(.W(W), .CW(8), .MAXBURST(0)) u_dut (
        .clock(clock), .reset(reset),
        .i0_d(i0_d), .i0_e(i0_e), .i0_v(i0_v), .i0_b(i0_b),
        .i1_d(i1_d), .i1_e(i1_e), .i1_v(i1_v), .i1_b(i1_b),
        .o_d(o_d), .o_e(o_e), .o_v(o_v), .o_b(o_b), .o_s(o_s)
    );

    zle_arb2 #(.W(W), .CW(8), .MAXBURST(4)) u_mb (
        .clock(clock), .reset(reset),
        .i0_d(i0_d), .i0_e(i0_e), .i0_v(i0_v), .i0_b(mb_i0_b),
        .i1_d(i1_d), .i1_e(i1_e), .i1_v(i1_v), .i1_b(mb_i1_b),
        .o_d(mb_o_d), .o_e(mb_o_e), .o_v(mb_o_v), .o_b(o_b), .o_s(mb_o_s)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge in between.
    task automatic to_sample();
        @(negedge clock);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, ".o_v"}, 8'(o_v), 8'd0);
        check({tag, ".o_e"}, 8'(o_e), 8'd0);
        check({tag, ".o_d"}, 8'(o_d), 8'd0);
        check({tag, ".o_s"}, 8'(o_s), 8'd0);
        check({tag, ".i0_b"}, 8'(i0_b), 8'd1);
        check({tag, ".i1_b"}, 8'(i1_b), 8'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        to_sample();
        idle_outputs("rst");
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i0_d = '0; i0_e = 1'b0; i0_v = 1'b0;
        i1_d = '0; i1_e = 1'b0; i1_v = 1'b0;
        o_b  = 1'b0;
        #2;
        idle_outputs("t0_reset");
        next_cycle();
        reset = 1'b0;

        // 1: i0 alone sends three tokens, eos on the third.
        i0_v = 1'b1; i0_d = 2'd1;
        to_sample();
        check("t1_idle.o_v", 8'(o_v), 8'd0);
        check("t1_idle.i0_b", 8'(i0_b), 8'd1);
        next_cycle();
        to_sample();
        check("t1_tok1.o_v", 8'(o_v), 8'd1);
        check("t1_tok1.o_d", 8'(o_d), 8'd1);
        check("t1_tok1.o_s", 8'(o_s), 8'd0);
        check("t1_tok1.i0_b", 8'(i0_b), 8'd0);
        check("t1_tok1.i1_b", 8'(i1_b), 8'd1);
        next_cycle();
        i0_d = 2'd2;
        to_sample();
        check("t1_tok2.o_d", 8'(o_d), 8'd2);
        check("t1_tok2.o_e", 8'(o_e), 8'd0);
        next_cycle();
        i0_d = 2'd3; i0_e = 1'b1;
        to_sample();
        check("t1_tok3.o_d", 8'(o_d), 8'd3);
        check("t1_tok3.o_e", 8'(o_e), 8'd1);
        next_cycle();
        i0_v = 1'b0; i0_e = 1'b0;
        to_sample();
        check("t1_after.o_v", 8'(o_v), 8'd0);
        next_cycle();

        // 2: both valid from reset, two-token segments, grants 0,1,0,1.
        i0_v = 1'b1; i1_v = 1'b1;
        do_reset();
        i0_d = 2'd1; i1_d = 2'd2;
        to_sample();
        check("t2_idle.o_v", 8'(o_v), 8'd0);
        next_cycle();
        to_sample();
        check("t2_s0a.o_s", 8'(o_s), 8'd0);
        check("t2_s0a.o_d", 8'(o_d), 8'd1);
        check("t2_s0a.i1_b", 8'(i1_b), 8'd1);
        next_cycle();
        i0_d = 2'd3; i0_e = 1'b1;
        to_sample();
        check("t2_s0b.o_e", 8'(o_e), 8'd1);
        check("t2_s0b.o_d", 8'(o_d), 8'd3);
        next_cycle();
        i0_d = 2'd0; i0_e = 1'b0;
        to_sample();
        check("t2_s1a.o_v", 8'(o_v), 8'd1);
        check("t2_s1a.o_s", 8'(o_s), 8'd1);
        check("t2_s1a.o_d", 8'(o_d), 8'd2);
        check("t2_s1a.i0_b", 8'(i0_b), 8'd1);
        next_cycle();
        i1_d = 2'd1; i1_e = 1'b1;
        to_sample();
        check("t2_s1b.o_s", 8'(o_s), 8'd1);
        check("t2_s1b.o_e", 8'(o_e), 8'd1);
        next_cycle();
        i1_d = 2'd3; i1_e = 1'b0; i0_e = 1'b1;
        to_sample();
        check("t2_s2.o_s", 8'(o_s), 8'd0);
        check("t2_s2.o_d", 8'(o_d), 8'd0);
        next_cycle();
        i0_e = 1'b0; i0_d = 2'd1;
        to_sample();
        check("t2_s3.o_s", 8'(o_s), 8'd1);
        check("t2_s3.o_d", 8'(o_d), 8'd3);

        // 3: i1 closes its segment; G0 then sees i0 pause for five cycles.
        next_cycle();
        i1_e = 1'b1; i1_d = 2'd0;
        to_sample();
        check("t3_close1.o_s", 8'(o_s), 8'd1);
        next_cycle();
        i1_e = 1'b0;
        to_sample();
        check("t3_g0.o_s", 8'(o_s), 8'd0);
        check("t3_g0.o_d", 8'(o_d), 8'd1);
        next_cycle();
        i0_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            to_sample();
            check("t3_gap.o_v", 8'(o_v), 8'd0);
            check("t3_gap.o_s", 8'(o_s), 8'd0);
            check("t3_gap.i1_b", 8'(i1_b), 8'd1);
            next_cycle();
        end
        i0_v = 1'b1; i0_d = 2'd2; i0_e = 1'b1;
        to_sample();
        check("t3_resume.o_v", 8'(o_v), 8'd1);
        check("t3_resume.o_d", 8'(o_d), 8'd2);
        check("t3_resume.o_s", 8'(o_s), 8'd0);
        check("t3_resume.i0_b", 8'(i0_b), 8'd0);
        next_cycle();
        i0_v = 1'b0; i0_e = 1'b0;
        to_sample();
        check("t3_switch.o_s", 8'(o_s), 8'd1);
        next_cycle();
        i1_v = 1'b0;

        // 4: downstream stalls a G0 segment for four cycles.
        i0_v = 1'b1; i0_d = 2'd1;
        do_reset();
        next_cycle();
        to_sample();
        check("t4_tok1.o_d", 8'(o_d), 8'd1);
        next_cycle();
        i0_d = 2'd2; o_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            to_sample();
            check("t4_stall.o_v", 8'(o_v), 8'd1);
            check("t4_stall.o_d", 8'(o_d), 8'd2);
            check("t4_stall.i0_b", 8'(i0_b), 8'd1);
            check("t4_stall.cnt", u_dut.cnt, 8'd1);
            next_cycle();
        end
        o_b = 1'b0;
        to_sample();
        check("t4_go.o_d", 8'(o_d), 8'd2);
        check("t4_go.i0_b", 8'(i0_b), 8'd0);
        next_cycle();
        to_sample();
        check("t4_after.cnt", u_dut.cnt, 8'd2);
        next_cycle();
        i0_v = 1'b0;

        // 5: MAXBURST=4 forces a switch after i0's fourth token.
        i0_v = 1'b1; i1_v = 1'b1; i1_d = 2'd3;
        do_reset();
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            i0_d = 2'(i);
            to_sample();
            check("t5_burst.o_s", 8'(mb_o_s), 8'd0);
            check("t5_burst.o_d", 8'(mb_o_d), 8'(i));
            next_cycle();
        end
        to_sample();
        check("t5_switch.o_s", 8'(mb_o_s), 8'd1);
        check("t5_switch.o_d", 8'(mb_o_d), 8'd3);
        check("t5_switch.i0_b", 8'(mb_i0_b), 8'd1);
        check("t5_switch.i1_b", 8'(mb_i1_b), 8'd0);
        check("t5_unlimited.o_s", 8'(o_s), 8'd0);
        next_cycle();

        // 6: reset mid-segment drops the grant at once; input 0 wins next.
        reset = 1'b1;
        #1;
        check("t6_rst.o_v", 8'(mb_o_v), 8'd0);
        check("t6_rst.i0_b", 8'(mb_i0_b), 8'd1);
        check("t6_rst.i1_b", 8'(mb_i1_b), 8'd1);
        next_cycle();
        reset = 1'b0;
        to_sample();
        check("t6_idle.o_v", 8'(mb_o_v), 8'd0);
        next_cycle();
        to_sample();
        check("t6_grant.o_v", 8'(mb_o_v), 8'd1);
        check("t6_grant.o_s", 8'(mb_o_s), 8'd0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
